// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: accepts (a, b, bin), computes a - b - bin
// LSB first over WIDTH cycles, then holds the result until downstream takes it.
//
// state | meaning
// IDLE  | waiting for an operand set; in_ready=1
// RUN   | one difference bit per edge, LSB first
// DONE  | result presented; out_valid=1 until out_ready
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic             sub_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] shift_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  // Full-subtractor cell on the current LSB of the operand shift registers.
  always_comb begin
    sub_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    shift_nxt = {sub_bit, shift_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          shift_d = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        br_d    = br_nxt;
        shift_d = shift_nxt;
        // Counter stops at the last bit so it never wraps within an operation.
        if (cnt_q == LAST_BIT) begin
          diff_d  = shift_nxt;
          bout_d  = br_nxt;
          zero_d  = (shift_nxt == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): reset, directed vectors,
// backpressure, reset during RUN and an exhaustive back-to-back sweep.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam int LAT_LIMIT = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } exp_t;

  exp_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    int   t;
    t    = int'(x) - int'(y) - int'(c);
    e.d  = t[W-1:0];
    e.bo = (t < 0);
    e.z  = (e.d == '0);
    return e;
  endfunction

  // Drives one operand set and waits for out_valid; reports what it saw, checks nothing.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        output int lat, output logic changed, output logic timeout);
    logic [W-1:0] d0;
    logic         b0, z0;
    a        = xa;
    b        = xb;
    bin      = xc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    d0 = diff; b0 = bout; z0 = zero;
    lat = 0; changed = 1'b0; timeout = 1'b0;
    while (!out_valid && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && (diff !== d0 || bout !== b0 || zero !== z0)) changed = 1'b1;
    end
    if (!out_valid) timeout = 1'b1;
  endtask

  task automatic test_reset;
    int seen;
    rst_n = 1'b0; in_valid = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (diff !== 4'd0) $display("FAIL reset_diff got=%0d exp=0", diff); else pass_cnt++;
    total_cnt++; if ({bout, zero} !== 2'b00) $display("FAIL reset_bout_zero got=%b exp=00", {bout, zero}); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    rst_n = 1'b1; in_valid = 1'b0;
    seen = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL reset_no_accept got=%0d valid cycles exp=0", seen); else pass_cnt++;
  endtask

  task automatic test_basic;
    logic [W-1:0] va[4] = '{4'd9, 4'd3, 4'd5, 4'd0};
    logic [W-1:0] vb[4] = '{4'd3, 4'd9, 4'd5, 4'd0};
    logic         vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int   lat;
    logic ch, to;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(va[i], vb[i], vc[i]));
      run_op(va[i], vb[i], vc[i], lat, ch, to);
      e = sb.pop_front();
      total_cnt++; if (to || lat != W) $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, lat, W); else pass_cnt++;
      total_cnt++; if (diff !== e.d) $display("FAIL basic_diff[%0d] got=%0d exp=%0d", i, diff, e.d); else pass_cnt++;
      total_cnt++; if ({bout, zero} !== {e.bo, e.z}) $display("FAIL basic_bout_zero[%0d] got=%b exp=%b", i, {bout, zero}, {e.bo, e.z}); else pass_cnt++;
      total_cnt++; if (ch !== 1'b0) $display("FAIL basic_run_stable[%0d] got=%b exp=0", i, ch); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done[%0d] got=%b exp=0", i, in_ready); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_after_xfer[%0d] got=%b exp=10", i, {in_ready, out_valid}); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    int   lat, seen;
    logic ch, to;
    exp_t e;
    out_ready = 1'b0;
    sb.push_back(model(4'd12, 4'd7, 1'b0));
    run_op(4'd12, 4'd7, 1'b0, lat, ch, to);
    e = sb.pop_front();
    total_cnt++; if (to || lat != W) $display("FAIL bp_latency got=%0d exp=%0d", lat, W); else pass_cnt++;
    a = 4'd1; b = 4'd1; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({out_valid, in_ready, diff, bout, zero} !== {1'b1, 1'b0, e.d, e.bo, e.z})
        $display("FAIL bp_hold[%0d] got v=%b r=%b d=%0d bo=%b z=%b exp v=1 r=0 d=%0d bo=%b z=%b",
                 i, out_valid, in_ready, diff, bout, zero, e.d, e.bo, e.z);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_xfer got=%b exp=10", {in_ready, out_valid}); else pass_cnt++;
    total_cnt++; if (diff !== 4'd5) $display("FAIL bp_retain got=%0d exp=5", diff); else pass_cnt++;
    seen = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL bp_second_ignored got=%0d valid cycles exp=0", seen); else pass_cnt++;
  endtask

  task automatic test_reset_in_run;
    int seen;
    out_ready = 1'b1;
    a = 4'd9; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total_cnt++;
    if ({out_valid, diff, bout, zero, in_ready} !== {1'b0, 4'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL run_reset got v=%b d=%0d bo=%b z=%b r=%b exp v=0 d=0 bo=0 z=0 r=1",
               out_valid, diff, bout, zero, in_ready);
    else pass_cnt++;
    seen = 0;
    repeat (2 * W + 2) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL run_reset_discard got=%0d valid cycles exp=0", seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int   lat, errs;
    logic ch, to;
    exp_t e;
    out_ready = 1'b1;
    errs = 0;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          sb.push_back(model(W'(ia), W'(ib), ic[0]));
          run_op(W'(ia), W'(ib), ic[0], lat, ch, to);
          e = sb.pop_front();
          total_cnt++;
          if (to || lat != W || diff !== e.d || bout !== e.bo || zero !== e.z || ch) begin
            if (errs < 10)
              $display("FAIL sweep a=%0d b=%0d bin=%0d got d=%0d bo=%b z=%b lat=%0d exp d=%0d bo=%b z=%b lat=%0d",
                       ia, ib, ic, diff, bout, zero, lat, e.d, e.bo, e.z, W);
            errs++;
          end else pass_cnt++;
          @(posedge clk); #1;
          total_cnt++;
          if (in_ready !== 1'b1) begin
            if (errs < 10) $display("FAIL sweep_ready a=%0d b=%0d bin=%0d got=%b exp=1", ia, ib, ic, in_ready);
            errs++;
          end else pass_cnt++;
        end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_in_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; legal range WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  operand set on a, b, bin is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  diff, bout and zero hold a completed result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
REQ-012 bout  output  1  borrow-out; 1 when a < b + bin.
REQ-013 zero  output  1  1 when diff == 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on an edge with in_valid=1, the block SHALL capture a, b, bin into internal registers, clear the bit counter, and enter RUN.
REQ-017 in_valid while in RUN or DONE SHALL be ignored; a, b, bin SHALL not be sampled.
REQ-018 RUN: one bit per cycle, LSB first; bit i SHALL be processed on the (i+1)-th edge after acceptance using d = a_i ^ b_i ^ br, br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br), br initialised to captured bin.
REQ-019 The partial difference SHALL accumulate in an internal shift register; diff, bout, zero SHALL NOT change during RUN.
REQ-020 On the edge processing bit WIDTH-1, the block SHALL load diff, bout (final br) and zero, and enter DONE; out_valid SHALL therefore be 1 exactly WIDTH cycles after the acceptance edge.
REQ-021 DONE: diff, bout, zero SHALL hold stable while out_ready=0, for any number of cycles.
REQ-022 DONE: on an edge with out_ready=1, the block SHALL enter IDLE; in_ready SHALL be 1 from the next cycle (no same-edge re-acceptance; minimum issue interval WIDTH+2 cycles).
REQ-023 diff, bout, zero SHALL retain the last result after the output transfer until the next result is loaded.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 Bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL not wrap inside a single operation.

Reset
REQ-026 With rst_n=0 at an edge, the block SHALL enter IDLE; out_valid=0, diff=0, bout=0, zero=0, internal shift, borrow and counter registers 0; in_ready=1 from the following cycle.
REQ-027 Reset SHALL take priority over every handshake, including in RUN or DONE; an in-flight operation SHALL be discarded with no result produced.
REQ-028 in_valid coincident with rst_n=0 SHALL not be accepted.

Verification (WIDTH=4)
REQ-029 a=9, b=3, bin=0, out_ready=1 -> out_valid high 4 cycles after accept; diff=6, bout=0, zero=0; in_ready=1 one cycle after transfer.
REQ-030 a=3, b=9, bin=0 -> diff=10, bout=1, zero=0.
REQ-031 a=5, b=5, bin=0 -> diff=0, bout=0, zero=1; a=0, b=0, bin=1 -> diff=15, bout=1, zero=0.
REQ-032 Backpressure: a=12, b=7, out_ready=0 for 3 cycles in DONE while in_valid=1 with a=1, b=1 -> diff=5, bout=0 stable all 3 cycles, in_ready=0, second operand not accepted; transfer on out_ready=1.
REQ-033 rst_n=0 on 2nd RUN cycle of a=9, b=3 -> next cycle out_valid=0, diff=0, bout=0, zero=0, in_ready=1; no result ever presented for that operand.
REQ-034 Exhaustive: all 512 (a, b, bin) combinations back-to-back -> each result equals (a - b - bin) mod 16, bout = (a < b + bin), latency 4 for every operation.
